// File: rtl/wb_block_reader.sv
// rtl/wb_block_reader.sv - Wishbone classic block reader feeding a FWFT FIFO stream
module wb_block_reader #(
  parameter int LEN_W      = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_adr,
  input  logic [LEN_W-1:0] length,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      wb_adr,
  output logic [31:0]      wb_dat_ms,
  input  logic [31:0]      wb_dat_sm,
  output logic [3:0]       wb_sel,
  output logic             wb_we,
  output logic             wb_stb,
  output logic             wb_cyc,
  input  logic             wb_ack,
  input  logic             wb_err,
  input  logic             wb_rty,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_RETRY,
    S_HOLD,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [31:0]      cur_adr;
  logic [LEN_W-1:0] rem;
  logic [31:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_nxt;
  logic             push, pop, accept;
  logic             unused_adr_bits;

  assign unused_adr_bits = ^base_adr[1:0];

  assign accept    = (state == S_IDLE) && start;
  assign push      = (state == S_RUN) && wb_ack && !wb_err;
  assign pop       = (count != '0) && out_ready;
  assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (length == '0)        state_nxt = S_DONE;
          // a leftover full FIFO from the previous command must drain first
          else if (count == FULL)  state_nxt = S_HOLD;
          else                     state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (wb_err) state_nxt = S_DONE;
        else if (wb_ack) begin
          if (rem == LEN_W'(1))        state_nxt = S_DONE;
          else if (count_nxt == FULL)  state_nxt = S_HOLD;
          else                         state_nxt = S_RUN;
        end
        else if (wb_rty) state_nxt = S_RETRY;
      end
      S_RETRY: state_nxt = S_RUN;
      S_HOLD:  if (count < FULL) state_nxt = S_RUN;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    wb_stb = 1'b0;
    busy   = 1'b1;
    done   = 1'b0;
    case (state)
      S_IDLE:  busy   = 1'b0;
      S_RUN:   wb_stb = 1'b1;
      S_DONE:  done   = 1'b1;
      default: ;
    endcase
  end

  assign wb_cyc    = wb_stb;
  assign wb_adr    = cur_adr;
  assign wb_dat_ms = 32'h0;
  assign wb_sel    = 4'hF;
  assign wb_we     = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_adr <= 32'h0;
      rem     <= '0;
      error   <= 1'b0;
    end else if (accept) begin
      cur_adr <= {base_adr[31:2], 2'b00};
      rem     <= length;
      error   <= 1'b0;
    end else if (state == S_RUN) begin
      if (wb_err) error <= 1'b1;
      else if (wb_ack) begin
        cur_adr <= cur_adr + 32'd4;
        rem     <= rem - LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wb_dat_sm;
  end

  // pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  assign out_data  = mem[rd_ptr];
  assign out_valid = (count != '0);

endmodule
